// File: rtl/branch_resolve_queue.sv
// In-order queue of branch predictions: each resolution pops the oldest entry and
// emits one registered update record (addr, outcome, mispredict) for the predictor demux.
module branch_resolve_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pred_valid,
  input  logic [AW-1:0]            pred_addr,
  input  logic                     pred_taken,
  output logic                     pred_ready,
  input  logic                     res_valid,
  input  logic                     res_taken,
  output logic                     upd_valid,
  output logic [AW-1:0]            addr,
  output logic                     otcome,
  output logic                     miss,
  output logic                     err_unmatched,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] addr_mem  [DEPTH];
  logic          taken_mem [DEPTH];
  logic [PW-1:0] wp_reg, rp_reg;
  logic [CW-1:0] count_reg;
  logic          push, pop, unmatched;

  // Ready ignores res_valid so a full queue never accepts a push, even alongside a pop.
  assign pred_ready = (count_reg != CW'(DEPTH));
  assign push       = pred_valid && pred_ready;
  assign pop        = res_valid && (count_reg != '0);
  assign unmatched  = res_valid && (count_reg == '0);
  assign count      = count_reg;

  // Entry storage carries no reset; pointers and count alone define occupancy.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wp_reg]  <= pred_addr;
      taken_mem[wp_reg] <= pred_taken;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_reg    <= '0;
      rp_reg    <= '0;
      count_reg <= '0;
    end else begin
      if (push) wp_reg <= wp_reg + PW'(1);
      if (pop)  rp_reg <= rp_reg + PW'(1);
      if (push && !pop)      count_reg <= count_reg + CW'(1);
      else if (pop && !push) count_reg <= count_reg - CW'(1);
    end
  end

  // Update record: addr/otcome/miss hold their last values when nothing pops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      upd_valid     <= 1'b0;
      addr          <= '0;
      otcome        <= 1'b0;
      miss          <= 1'b0;
      err_unmatched <= 1'b0;
    end else begin
      upd_valid     <= pop;
      err_unmatched <= unmatched;
      if (pop) begin
        addr   <= addr_mem[rp_reg];
        otcome <= res_taken;
        miss   <= taken_mem[rp_reg] ^ res_taken;
      end
    end
  end
endmodule

// File: tb/tb_branch_resolve_queue.sv
// Randomized scoreboard bench: a queue-based model predicts each update record,
// a negedge monitor pops and compares whenever the DUT presents one.
module tb_branch_resolve_queue;
  localparam int DEPTH = 4;
  localparam int AW    = 3;

  typedef struct {
    logic [AW-1:0] a;
    logic          t;
  } ent_t;

  typedef struct {
    logic [AW-1:0] a;
    logic          o;
    logic          m;
  } upd_t;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  pred_valid, pred_taken, res_valid, res_taken;
  logic [AW-1:0]         pred_addr;
  logic                  pred_ready, upd_valid, otcome, miss, err_unmatched;
  logic [AW-1:0]         addr;
  logic [$clog2(DEPTH):0] count;

  branch_resolve_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .pred_valid(pred_valid), .pred_addr(pred_addr), .pred_taken(pred_taken),
    .pred_ready(pred_ready),
    .res_valid(res_valid), .res_taken(res_taken),
    .upd_valid(upd_valid), .addr(addr), .otcome(otcome), .miss(miss),
    .err_unmatched(err_unmatched), .count(count)
  );

  always #5 clk = ~clk;

  ent_t mq[$];
  upd_t exp_q[$];
  int   exp_count = 0;
  bit   exp_ready = 1'b1;
  bit   exp_upd   = 1'b0;
  bit   exp_err   = 1'b0;
  int   tests = 0;
  int   fails = 0;
  int   n_upd = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: per-cycle status checks plus scoreboard pop on every update.
  always @(negedge clk) begin
    upd_t e;
    check("count", int'(count), exp_count);
    check("pred_ready", int'(pred_ready), int'(exp_ready));
    check("upd_valid", int'(upd_valid), int'(exp_upd));
    check("err_unmatched", int'(err_unmatched), int'(exp_err));
    if (upd_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_update", 1, 0);
      end else begin
        e = exp_q.pop_front();
        n_upd++;
        $display("[TB] update #%0d addr=%0d otcome=%0d miss=%0d (exp %0d/%0d/%0d)",
                 n_upd, addr, otcome, miss, e.a, e.o, e.m);
        check("addr", int'(addr), int'(e.a));
        check("otcome", int'(otcome), int'(e.o));
        check("miss", int'(miss), int'(e.m));
      end
    end
  end

  // One clock of stimulus; the model applies the queue rules at the same edge.
  task automatic step(input bit pv, input logic [AW-1:0] pa, input bit pt,
                      input bit rv, input bit rt);
    bit   ready, do_pop;
    ent_t e;
    pred_valid = pv; pred_addr = pa; pred_taken = pt;
    res_valid  = rv; res_taken = rt;
    @(posedge clk);
    ready  = (mq.size() != DEPTH);
    do_pop = rv && (mq.size() != 0);
    exp_upd = do_pop;
    exp_err = rv && (mq.size() == 0);
    if (do_pop) begin
      e = mq.pop_front();
      exp_q.push_back('{a: e.a, o: rt, m: e.t ^ rt});
    end
    if (pv && ready) mq.push_back('{a: pa, t: pt});
    exp_count = mq.size();
    exp_ready = (mq.size() != DEPTH);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, '0, 0, 0, 0);
  endtask

  // Asynchronous reset pulse of half a cycle, starting mid-cycle.
  task automatic async_reset();
    pred_valid = 0; res_valid = 0;
    #1 rst = 1'b1;
    mq.delete();
    exp_q.delete();
    exp_count = 0; exp_ready = 1'b1; exp_upd = 1'b0; exp_err = 1'b0;
    #1;
    check("rst_count", int'(count), 0);
    check("rst_ready", int'(pred_ready), 1);
    check("rst_upd_valid", int'(upd_valid), 0);
    check("rst_err", int'(err_unmatched), 0);
    @(negedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    pred_valid = 0; pred_addr = '0; pred_taken = 0; res_valid = 0; res_taken = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // 1: single push then matching resolve
    step(1, 3'b001, 1, 0, 0);
    step(0, '0, 0, 1, 1);
    idle(1);
    // 2: two pushes, resolve both as mispredicts
    step(1, 3'b001, 1, 0, 0);
    step(1, 3'b010, 0, 0, 0);
    step(0, '0, 0, 1, 0);
    step(0, '0, 0, 1, 1);
    idle(1);
    // 3: fill, rejected fifth push, drain
    step(1, 3'b100, 0, 0, 0);
    step(1, 3'b101, 1, 0, 0);
    step(1, 3'b110, 0, 0, 0);
    step(1, 3'b011, 1, 0, 0);
    step(1, 3'b111, 1, 0, 0);
    check("full_count", int'(count), DEPTH);
    check("full_ready", int'(pred_ready), 0);
    for (int i = 0; i < 4; i++) step(0, '0, 0, 1, i[0]);
    idle(1);
    // 4: steady push+pop across the pointer wrap
    step(1, 3'b000, 1, 0, 0);
    step(1, 3'b001, 0, 0, 0);
    for (int i = 0; i < 6; i++) step(1, AW'(i + 2), i[1], 1, i[0]);
    check("steady_count", int'(count), 2);
    step(0, '0, 0, 1, 0);
    step(0, '0, 0, 1, 1);
    idle(1);
    // 5: unmatched resolution with simultaneous push, no bypass
    step(1, 3'b011, 1, 1, 1);
    check("unmatched_pulse", int'(err_unmatched), 1);
    step(0, '0, 0, 1, 0);
    idle(1);
    // 6: async reset with 3 queued, then unmatched resolve
    step(1, 3'b001, 0, 0, 0);
    step(1, 3'b010, 1, 0, 0);
    step(1, 3'b100, 0, 0, 0);
    async_reset();
    step(0, '0, 0, 1, 1);
    check("post_rst_err", int'(err_unmatched), 1);
    idle(1);

    // Randomized traffic, with one reset in the middle
    for (int i = 0; i < 400; i++) begin
      if (i == 200) async_reset();
      step($urandom_range(0, 99) < 55, AW'($urandom), 1'($urandom),
           $urandom_range(0, 99) < 50, 1'($urandom));
    end
    idle(2);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/branch_resolve_queue.md
# branch_resolve_queue

Producer side of the predictor-update interface: holds the prediction made for each in-flight branch and, when that branch resolves, emits one registered update record (addr, otcome, miss) for the 1-to-2 outcome demux to route to predictor A or B. It sits between the fetch-side prediction path and the update demux, converting two decoupled event streams into a single in-order update stream. Internally it is a DEPTH-entry circular FIFO of {addr, predicted direction} with occupancy counting and a registered compare stage.

## Interface

- DEPTH, 4, number of in-flight branch entries; power of two, at least 2
- AW, 3, branch address / predictor-select width; matches the demux addr width
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- pred_valid  input  1  a prediction is issued this cycle
- pred_addr  input  AW  address of the predicted branch
- pred_taken  input  1  predicted direction (1 = taken)
- pred_ready  output  1  queue can accept a prediction; combinational, equals (count != DEPTH)
- res_valid  input  1  the oldest in-flight branch resolves this cycle
- res_taken  input  1  actual direction of that branch
- upd_valid  output  1  update record valid this cycle (one-cycle pulse per resolution)
- addr  output  AW  address of the resolved branch
- otcome  output  1  actual outcome, a registered copy of res_taken
- miss  output  1  1 when the predicted direction differs from the actual outcome
- err_unmatched  output  1  one-cycle pulse: res_valid arrived while the queue was empty
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH

## Operation

- Storage: DEPTH entries of {addr[AW-1:0], taken}.
- Pointers: write pointer wp and read pointer rp, each $clog2(DEPTH) bits; both wrap modulo DEPTH.
- Push: when pred_valid && pred_ready, write {pred_addr, pred_taken} at wp, then wp+1 and count+1.
  - When the queue is full, a push is ignored with no state change.
  - This holds even if a pop happens in the same cycle: pred_ready does not look at res_valid.
- Pop: when res_valid && count != 0:
  - read the entry at rp, then rp+1 and count-1;
  - register upd_valid=1, addr=entry.addr, otcome=res_taken, miss=entry.taken ^ res_taken.
- Unmatched resolution: when res_valid && count == 0:
  - no pop and no update; register err_unmatched=1;
  - upd_valid stays 0; addr, otcome and miss hold their previous values.
- Simultaneous push and pop (not full, not empty): both take effect, count is unchanged, and the popped entry is the old head.
- Push into an empty queue with res_valid in the same cycle: no bypass. The resolution is unmatched (err_unmatched pulses) and the push is accepted (count becomes 1).
- Ordering: updates leave strictly in push order. The block assumes resolutions arrive in program order and does no tag matching.
- Reset (asynchronous, any time):
  - wp, rp and count go to 0; all entries are discarded;
  - upd_valid, addr, otcome, miss and err_unmatched go to 0;
  - pred_ready reads 1 while rst is held and after release.

## Timing

- Push latency: an entry written at edge N is poppable by a res_valid sampled at edge N+1.
- Update latency: res_valid sampled at edge N gives upd_valid/addr/otcome/miss valid after edge N, for exactly one cycle.
- Back-to-back res_valid gives an update every cycle with no bubbles.
- err_unmatched has the same one-cycle latency and pulse width as upd_valid; the two are never high together.
- count and pred_ready reflect the post-edge state in the same cycle the pointers update.
- Wrap-around: after DEPTH pushes, wp returns to 0. Occupancy comes from count, never from pointer equality alone.

## Test plan

1. Reset, then push {addr=3'b001, taken=1}; next cycle res_valid with res_taken=1 -> one cycle later upd_valid=1, addr=001, otcome=1, miss=0, count=0.
2. Push {001,1} then {010,0}; resolve with res_taken=0, then 1 -> updates in order: (001, otcome 0, miss 1), then (010, otcome 1, miss 1).
3. Push 4 entries with no resolutions -> count=4, pred_ready=0. A 5th push (addr 3'b111) is ignored. Then 4 resolutions -> exactly 4 updates with the original addresses, count=0.
4. With 2 entries queued, assert push and res_valid together for 6 cycles -> count stays 2, updates come out in push order across the pointer wrap, no err_unmatched.
5. Empty queue: res_valid=1 with a simultaneous push {011,1} -> err_unmatched=1 for one cycle, upd_valid=0, count=1. The next res_valid (taken=0) -> addr=011, miss=1.
6. Assert rst for half a cycle while 3 entries are queued -> count=0, pred_ready=1, upd_valid=0 immediately. A following res_valid -> err_unmatched=1.
